// File: rtl/mem_resp_router.sv
// Routes in-order shared-memory responses back to imem or dmem using a FIFO of request tags.
// Responses that arrive with nothing tracked are dropped and latched into a sticky orphan flag.
module mem_resp_router #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  input  logic                         req_src,
  output logic                         req_ready,
  input  logic                         resp_valid,
  input  logic [XLEN-1:0]              resp_data,
  output logic                         imem_resp_valid,
  output logic [XLEN-1:0]              imem_resp_data,
  output logic                         dmem_resp_valid,
  output logic [XLEN-1:0]              dmem_resp_data,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding,
  output logic                         orphan_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] PtrOne    = PW'(1);
  localparam logic [CW-1:0] CntOne    = CW'(1);
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("mem_resp_router: DEPTH must be a power of two and at least 2");
  end

  logic [DEPTH-1:0] r_tags;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_imem_valid;
  logic [XLEN-1:0]  r_imem_data;
  logic             r_dmem_valid;
  logic [XLEN-1:0]  r_dmem_data;
  logic             r_orphan;

  logic w_accept;
  logic w_retire;
  logic w_orphan;
  logic w_tag;
  logic w_to_imem;
  logic w_to_dmem;

  // Ready depends on registered count only, so a retire on a full edge cannot admit a request.
  assign req_ready = (r_count != FullCount);
  assign w_accept  = req_valid && req_ready;
  assign w_retire  = resp_valid && (r_count != '0);
  assign w_orphan  = resp_valid && (r_count == '0);
  assign w_tag     = r_tags[r_rd_ptr];
  assign w_to_imem = w_retire && !w_tag;
  assign w_to_dmem = w_retire && w_tag;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tags       <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_imem_valid <= 1'b0;
      r_imem_data  <= '0;
      r_dmem_valid <= 1'b0;
      r_dmem_data  <= '0;
      r_orphan     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tags[r_wr_ptr] <= req_src;
        r_wr_ptr         <= r_wr_ptr + PtrOne;
      end
      if (w_retire) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
      end
      unique case ({w_accept, w_retire})
        2'b10:   r_count <= r_count + CntOne;
        2'b01:   r_count <= r_count - CntOne;
        default: r_count <= r_count;
      endcase
      r_imem_valid <= w_to_imem;
      r_dmem_valid <= w_to_dmem;
      if (w_to_imem) begin
        r_imem_data <= resp_data;
      end
      if (w_to_dmem) begin
        r_dmem_data <= resp_data;
      end
      if (w_orphan) begin
        r_orphan <= 1'b1;
      end
    end
  end

  assign imem_resp_valid = r_imem_valid;
  assign imem_resp_data  = r_imem_data;
  assign dmem_resp_valid = r_dmem_valid;
  assign dmem_resp_data  = r_dmem_data;
  assign outstanding     = r_count;
  assign orphan_err      = r_orphan;

endmodule

// File: tb/tb_mem_resp_router.sv
// Directed self-checking bench for mem_resp_router with DEPTH=4, XLEN=32.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
module tb_mem_resp_router;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH+1);

  logic            clk;
  logic            reset;
  logic            req_valid;
  logic            req_src;
  logic            req_ready;
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            dmem_resp_valid;
  logic [XLEN-1:0] dmem_resp_data;
  logic [CW-1:0]   outstanding;
  logic            orphan_err;

  int n_tests = 0;
  int n_fail  = 0;

  mem_resp_router #(
    .XLEN (XLEN),
    .DEPTH(DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_src        (req_src),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .dmem_resp_valid(dmem_resp_valid),
    .dmem_resp_data (dmem_resp_data),
    .outstanding    (outstanding),
    .orphan_err     (orphan_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid  = 1'b0;
    req_src    = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (outstanding !== 0) begin
      n_fail++; $display("FAIL reset_outstanding: got %0d want 0", outstanding);
    end
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready);
    end
    n_tests++;
    if ({imem_resp_valid, dmem_resp_valid, orphan_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000",
                         {imem_resp_valid, dmem_resp_valid, orphan_err});
    end
    n_tests++;
    if ({imem_resp_data, dmem_resp_data} !== 64'h0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h want 0/0", imem_resp_data, dmem_resp_data);
    end
  endtask

  task automatic test_ordering();
    logic [2:0]  srcs;
    logic [31:0] datas [3];
    logic [31:0] exp_i;
    logic [31:0] exp_d;
    srcs = 3'b010;  // issue order: imem, dmem, imem
    datas[0] = 32'h11; datas[1] = 32'h22; datas[2] = 32'h33;
    exp_i = imem_resp_data;
    exp_d = dmem_resp_data;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_src = srcs[i];
      tick();
    end
    idle();
    n_tests++;
    if (outstanding !== 3) begin
      n_fail++; $display("FAIL order_issue_count: got %0d want 3", outstanding);
    end
    for (int i = 0; i < 3; i++) begin
      resp_valid = 1'b1; resp_data = datas[i];
      tick();
      if (srcs[i]) exp_d = datas[i]; else exp_i = datas[i];
      n_tests++;
      if ({imem_resp_valid, dmem_resp_valid} !== {!srcs[i], srcs[i]} ||
          imem_resp_data !== exp_i || dmem_resp_data !== exp_d || outstanding !== CW'(2 - i)) begin
        n_fail++;
        $display("FAIL order_resp%0d: got iv=%b dv=%b id=%h dd=%h out=%0d want iv=%b dv=%b id=%h dd=%h out=%0d",
                 i, imem_resp_valid, dmem_resp_valid, imem_resp_data, dmem_resp_data, outstanding,
                 !srcs[i], srcs[i], exp_i, exp_d, 2 - i);
      end
    end
    idle();
    tick();
    n_tests++;
    if ({imem_resp_valid, dmem_resp_valid} !== 2'b00 || imem_resp_data !== 32'h33 ||
        dmem_resp_data !== 32'h22) begin
      n_fail++; $display("FAIL order_idle: got iv=%b dv=%b id=%h dd=%h want 0 0 33 22",
                         imem_resp_valid, dmem_resp_valid, imem_resp_data, dmem_resp_data);
    end
  endtask

  // Leaves 4 tags (0,1,1,0) in the tracker with pointers wrapped.
  task automatic test_full();
    logic [4:0] srcs;
    srcs = 5'b10110;  // bit i = source of request i
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_src = srcs[i];
      tick();
      if (i == 3) begin
        n_tests++;
        if (req_ready !== 1'b0 || outstanding !== 4) begin
          n_fail++; $display("FAIL full_after4: got ready=%b out=%0d want ready=0 out=4",
                             req_ready, outstanding);
        end
      end
    end
    idle();
    n_tests++;
    if (outstanding !== 4 || req_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_fifth_ignored: got ready=%b out=%0d want ready=0 out=4",
                         req_ready, outstanding);
    end
  endtask

  task automatic test_full_simultaneous();
    logic [2:0]  rest;
    // Full edge: the response retires tag 0, the dmem request (src=1) must be dropped.
    req_valid = 1'b1; req_src = 1'b1; resp_valid = 1'b1; resp_data = 32'hA0;
    tick();
    idle();
    n_tests++;
    if (outstanding !== 3 || req_ready !== 1'b1 || imem_resp_valid !== 1'b1 ||
        dmem_resp_valid !== 1'b0 || imem_resp_data !== 32'hA0) begin
      n_fail++; $display("FAIL full_simul: got out=%0d ready=%b iv=%b dv=%b id=%h want 3 1 1 0 a0",
                         outstanding, req_ready, imem_resp_valid, dmem_resp_valid, imem_resp_data);
    end
    rest = 3'b011;  // remaining tags 1,1,0; a leaked request would add a 4th
    for (int i = 0; i < 3; i++) begin
      resp_valid = 1'b1; resp_data = 32'hB0 + 32'(i);
      tick();
      n_tests++;
      if ({imem_resp_valid, dmem_resp_valid} !== {!rest[i], rest[i]}) begin
        n_fail++; $display("FAIL full_drain%0d: got iv=%b dv=%b want iv=%b dv=%b",
                           i, imem_resp_valid, dmem_resp_valid, !rest[i], rest[i]);
      end
    end
    idle();
    n_tests++;
    if (outstanding !== 0 || dmem_resp_data !== 32'hB1) begin
      n_fail++; $display("FAIL full_drain_end: got out=%0d dd=%h want 0 b1", outstanding, dmem_resp_data);
    end
  endtask

  task automatic test_back_to_back();
    logic        q[$];
    logic        exp_tag;
    logic        src;
    logic [31:0] exp_i;
    logic [31:0] exp_d;
    exp_i = imem_resp_data;
    exp_d = dmem_resp_data;
    req_valid = 1'b1; req_src = 1'b0;
    tick();
    q.push_back(1'b0);
    for (int i = 0; i < 11; i++) begin
      src = (i % 2 == 0);
      req_valid  = (i < 10);
      req_src    = src;
      resp_valid = 1'b1;
      resp_data  = 32'h100 + 32'(i);
      tick();
      if (i < 10) q.push_back(src);
      exp_tag = q.pop_front();
      if (exp_tag) exp_d = resp_data; else exp_i = resp_data;
      n_tests++;
      if ({imem_resp_valid, dmem_resp_valid} !== {!exp_tag, exp_tag} || imem_resp_data !== exp_i ||
          dmem_resp_data !== exp_d || outstanding !== CW'(q.size())) begin
        n_fail++;
        $display("FAIL steady%0d: got iv=%b dv=%b id=%h dd=%h out=%0d want iv=%b dv=%b id=%h dd=%h out=%0d",
                 i, imem_resp_valid, dmem_resp_valid, imem_resp_data, dmem_resp_data, outstanding,
                 !exp_tag, exp_tag, exp_i, exp_d, q.size());
      end
    end
    idle();
  endtask

  task automatic test_orphan();
    // Response on an empty tracker with a simultaneous dmem request: drop response, keep request.
    req_valid = 1'b1; req_src = 1'b1; resp_valid = 1'b1; resp_data = 32'hDEAD;
    tick();
    idle();
    n_tests++;
    if ({imem_resp_valid, dmem_resp_valid} !== 2'b00 || orphan_err !== 1'b1 || outstanding !== 1) begin
      n_fail++; $display("FAIL orphan_set: got iv=%b dv=%b err=%b out=%0d want 0 0 1 1",
                         imem_resp_valid, dmem_resp_valid, orphan_err, outstanding);
    end
    tick();
    tick();
    n_tests++;
    if (orphan_err !== 1'b1) begin
      n_fail++; $display("FAIL orphan_sticky: got %b want 1", orphan_err);
    end
    resp_valid = 1'b1; resp_data = 32'h55;
    tick();
    idle();
    n_tests++;
    if (dmem_resp_valid !== 1'b1 || dmem_resp_data !== 32'h55 || imem_resp_valid !== 1'b0 ||
        orphan_err !== 1'b1 || outstanding !== 0) begin
      n_fail++; $display("FAIL orphan_no_bypass: got dv=%b dd=%h iv=%b err=%b out=%0d want 1 55 0 1 0",
                         dmem_resp_valid, dmem_resp_data, imem_resp_valid, orphan_err, outstanding);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    n_tests++;
    if (orphan_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_clears_orphan: got %b want 0", orphan_err);
    end
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_src = i[0];
      tick();
    end
    idle();
    n_tests++;
    if (outstanding !== 3) begin
      n_fail++; $display("FAIL mid_issue: got %0d want 3", outstanding);
    end
    reset = 1'b1; req_valid = 1'b1; req_src = 1'b0; resp_valid = 1'b1; resp_data = 32'h99;
    tick();
    reset = 1'b0;
    idle();
    n_tests++;
    if (outstanding !== 0 || {imem_resp_valid, dmem_resp_valid, orphan_err} !== 3'b000 ||
        req_ready !== 1'b1 || imem_resp_data !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset: got out=%0d iv=%b dv=%b err=%b ready=%b id=%h want 0 0 0 0 1 0",
                         outstanding, imem_resp_valid, dmem_resp_valid, orphan_err, req_ready,
                         imem_resp_data);
    end
    resp_valid = 1'b1; resp_data = 32'h77;
    tick();
    idle();
    n_tests++;
    if (orphan_err !== 1'b1 || {imem_resp_valid, dmem_resp_valid} !== 2'b00) begin
      n_fail++; $display("FAIL mid_orphan: got err=%b iv=%b dv=%b want 1 0 0",
                         orphan_err, imem_resp_valid, dmem_resp_valid);
    end
  endtask

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_ordering();
    test_full();
    test_full_simultaneous();
    test_back_to_back();
    test_orphan();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_resp_router.md
MEM_RESP_ROUTER -- requirements
Module: mem_resp_router

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the response data width.
REQ-002 Parameter DEPTH, default 4, SHALL set the outstanding-request tracker depth; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL use one clock, clk, and one reset, reset; reset SHALL be synchronous and active-high.
REQ-004 The ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  clock, rising edge
- reset  in  1  synchronous active-high reset
- req_valid  in  1  shared memory request issued this cycle
- req_src  in  1  requester of the issued request: 0 = imem, 1 = dmem
- req_ready  out  1  tracker can accept a request
- resp_valid  in  1  shared memory response present
- resp_data  in  XLEN  response data
- imem_resp_valid  out  1  response for imem
- imem_resp_data  out  XLEN  imem response data
- dmem_resp_valid  out  1  response for dmem
- dmem_resp_data  out  XLEN  dmem response data
- outstanding  out  $clog2(DEPTH+1)  number of tracked requests
- orphan_err  out  1  sticky flag: response received with no request tracked

Function
REQ-005 The tracker SHALL be an in-order FIFO of req_src tags, DEPTH entries, with write and read pointers of width $clog2(DEPTH) that wrap modulo DEPTH.
REQ-006 req_ready SHALL equal (outstanding != DEPTH), derived combinationally from registered state only.
REQ-007 A request SHALL be accepted on a clock edge where req_valid && req_ready; req_src is written at the write pointer, and the write pointer advances.
REQ-008 When req_valid is high and req_ready is low, the request SHALL be ignored, and no state SHALL change from it.
REQ-009 A response SHALL be retired on a clock edge where resp_valid && outstanding != 0; the tag at the read pointer selects the destination, and the read pointer advances.
REQ-010 Response latency SHALL be exactly 1 cycle: the selected port's *_resp_valid is high, and its *_resp_data equals resp_data, in the cycle after retirement.
REQ-011 At most one of imem_resp_valid and dmem_resp_valid SHALL be high in any cycle.
REQ-012 The non-selected port's valid SHALL be 0 and its data SHALL hold its previous value.
REQ-013 Response data registers SHALL load only on retirement to their own port.
REQ-014 On an edge with simultaneous accept and retire, outstanding SHALL remain unchanged and both pointers SHALL advance.
REQ-015 Accept-only SHALL increment outstanding; retire-only SHALL decrement it.
REQ-016 No bypass: a response with outstanding == 0 SHALL NOT match a request accepted on the same edge.
REQ-017 In that case (outstanding == 0 with resp_valid), the response SHALL be dropped, no port valid SHALL assert, orphan_err SHALL set and stay set until reset, and the request SHALL still be accepted.
REQ-018 When the tracker is full, a response and a request on the same edge SHALL retire the response and reject the request, because req_ready is low.
REQ-019 Tags SHALL be returned strictly in issue order, including across pointer wrap-around.

Reset
REQ-020 On a reset edge, the pointers, outstanding, imem_resp_valid, dmem_resp_valid and orphan_err SHALL become 0, and imem_resp_data and dmem_resp_data SHALL become 0.
REQ-021 Reset SHALL take priority over simultaneous req_valid and resp_valid; tracked requests SHALL be discarded, and responses arriving after reset SHALL be treated as orphans.
REQ-022 req_ready SHALL be 1 in the first cycle after reset.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Ordering: issue imem, dmem, imem; then respond 0x11, 0x22, 0x33 on consecutive cycles -> imem gets 0x11, dmem gets 0x22, imem gets 0x33, each 1 cycle after its resp; outstanding goes 3, 2, 1, 0.
- Full: issue 5 requests back-to-back with DEPTH=4 -> req_ready=0 after the 4th, the 5th is ignored, outstanding=4.
- Full plus simultaneous: with 4 outstanding, assert req and resp on the same edge -> one retire, request rejected, outstanding=3.
- Steady state: alternate imem and dmem with req and resp on the same cycle for 10 cycles -> outstanding constant, order preserved across pointer wrap.
- Orphan: assert resp_valid with data 0xDEAD while empty -> no port valid, orphan_err=1 and stays 1 until reset.
- Reset mid-operation: 3 outstanding, then reset -> outstanding=0, all valids 0; a following resp sets orphan_err.
